// File: rtl/jk_sync_counter.sv
// jk_sync_counter: up/down modulo counter built from JK toggle cells.
// Each bit toggles when its t[i] is high (J = K = t[i]). The toggle vector
// is decoded from load, en, up and the wrap condition. The sequence runs
// over 0..modulus. tc is a registered pulse that marks a wrap, and ovf is
// a sticky copy of that pulse.
module jk_sync_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] modulus,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_up_t;    // toggle vector for q+1
    logic [WIDTH-1:0] w_dn_t;    // toggle vector for q-1
    logic [WIDTH-1:0] w_t;       // selected toggle vector (J = K)
    logic             w_at_top;  // q at or beyond terminal value
    logic             w_at_zero;
    logic             w_wrap;

    // Bit 0 always toggles on increment/decrement.
    assign w_up_t[0] = 1'b1;
    assign w_dn_t[0] = 1'b1;

    // Higher bits use the classic synchronous counter rule. A bit toggles
    // when all lower bits are 1 (up) or when all lower bits are 0 (down).
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign w_up_t[i] = w_up_t[i-1] & r_q[i-1];
        assign w_dn_t[i] = w_dn_t[i-1] & ~r_q[i-1];
    end

    // Use >= so that an out-of-range value (loaded above modulus) still
    // wraps to 0 on the next up-count.
    assign w_at_top  = (r_q >= modulus);
    assign w_at_zero = (r_q == '0);

    // Choose toggle bits by priority: load > count > hold.
    always_comb begin
        w_t    = '0;
        w_wrap = 1'b0;
        if (load) begin
            // Toggle exactly the bits that differ from din.
            w_t = r_q ^ din;
        end else if (en) begin
            if (up) begin
                if (w_at_top) begin
                    // Toggle every set bit to reach 0.
                    w_t    = r_q;
                    w_wrap = 1'b1;
                end else begin
                    w_t = w_up_t;
                end
            end else begin
                if (w_at_zero) begin
                    // Starting from 0, toggling the modulus bits lands on modulus.
                    w_t    = modulus;
                    w_wrap = 1'b1;
                end else begin
                    w_t = w_dn_t;
                end
            end
        end
    end

    // JK cells, one per bit, with J = K = t: next = J & ~q | ~K & q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= (w_t & ~r_q) | (~w_t & r_q);
        end
    end

    // Wrap pulse, registered alongside q so it lines up with the wrapped value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_wrap;
        end
    end

    // Sticky overflow flag. A wrap takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Testbench for jk_sync_counter (WIDTH=4). A behavioural model in integer
// arithmetic is compared with the DUT on every falling edge. Directed
// scenarios fix literal expectations, and a randomized phase follows them.
module tb_jk_sync_counter;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] modulus;
    logic         clr_ovf;
    logic [W-1:0] q;
    logic         tc;
    logic         ovf;

    int   n_vec = 0;
    int   n_bad = 0;

    // Model state.
    int   m_q   = 0;
    logic m_tc  = 1'b0;
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .din     (din),
        .modulus (modulus),
        .clr_ovf (clr_ovf),
        .q       (q),
        .tc      (tc),
        .ovf     (ovf)
    );

    function automatic logic f_wrap(int cq, logic l, logic e, logic u, int md);
        if (l || !e) return 1'b0;
        if (u) return (cq >= md);
        return (cq == 0);
    endfunction

    function automatic int f_next(int cq, logic l, logic e, logic u, int d, int md);
        if (l) return d & MASK;
        if (!e) return cq;
        if (u) return (cq >= md) ? 0 : ((cq + 1) & MASK);
        return (cq == 0) ? md : ((cq - 1) & MASK);
    endfunction

    // Reference model, advanced on the same events as the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   <= 0;
            m_tc  <= 1'b0;
            m_ovf <= 1'b0;
        end else begin
            m_q  <= f_next(m_q, load, en, up, int'(din), int'(modulus));
            m_tc <= f_wrap(m_q, load, en, up, int'(modulus));
            if (f_wrap(m_q, load, en, up, int'(modulus))) m_ovf <= 1'b1;
            else if (clr_ovf)                             m_ovf <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("model_q", int'(q), m_q);
        chk("model_tc", int'(tc), int'(m_tc));
        chk("model_ovf", int'(ovf), int'(m_ovf));
    endtask

    // Advance one clock and compare against the model at the falling edge.
    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic drive(input logic l, input logic e, input logic u, input int d,
                         input int md, input logic c);
        load    = l;
        en      = e;
        up      = u;
        din     = d[W-1:0];
        modulus = md[W-1:0];
        clr_ovf = c;
    endtask

    // Pulse rst between edges and check that outputs clear before the next edge.
    task automatic async_pulse(input logic lit);
        #1 rst = 1'b1;
        #1;
        if (lit) begin
            chk("async_q", int'(q), 0);
            chk("async_tc", int'(tc), 0);
            chk("async_ovf", int'(ovf), 0);
        end
        cmp_model();
        #1 rst = 1'b0;
    endtask

    initial begin
        int exp_up[12];
        int exp_dn[4];
        exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        exp_dn = '{1, 0, 5, 4};

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("reset_q", int'(q), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst = 1'b0;

        // Count up with modulus 9.
        drive(1'b0, 1'b1, 1'b1, 0, 9, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("up_q", int'(q), exp_up[i]);
            chk("up_tc", int'(tc), (i == 9) ? 1 : 0);
        end
        chk("up_ovf", int'(ovf), 1);

        // Load 2, then count down with modulus 5.
        drive(1'b1, 1'b0, 1'b0, 2, 5, 1'b0);
        tick();
        chk("dn_load_q", int'(q), 2);
        drive(1'b0, 1'b1, 1'b0, 0, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dn_q", int'(q), exp_dn[i]);
            chk("dn_tc", int'(tc), (i == 2) ? 1 : 0);
        end

        // Load a value above modulus, then count up and down from it.
        drive(1'b1, 1'b1, 1'b1, 12, 5, 1'b0);
        tick();
        chk("oor_load_q", int'(q), 12);
        chk("oor_load_tc", int'(tc), 0);
        drive(1'b0, 1'b1, 1'b1, 0, 5, 1'b0);
        tick();
        chk("oor_up_q", int'(q), 0);
        chk("oor_up_tc", int'(tc), 1);
        drive(1'b1, 1'b0, 1'b0, 12, 5, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 0, 5, 1'b0);
        tick();
        chk("oor_dn_q", int'(q), 11);
        chk("oor_dn_tc", int'(tc), 0);

        // Load takes priority over count, then hold.
        drive(1'b1, 1'b1, 1'b1, 7, 5, 1'b0);
        tick();
        chk("prio_q", int'(q), 7);
        chk("prio_tc", int'(tc), 0);
        drive(1'b0, 1'b0, 1'b1, 3, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q", int'(q), 7);
            chk("hold_tc", int'(tc), 0);
        end

        // Flag control: clear, then clear during a wrap, then clear alone.
        drive(1'b1, 1'b0, 1'b1, 5, 5, 1'b1);
        tick();
        chk("clr_ovf0", int'(ovf), 0);
        drive(1'b0, 1'b1, 1'b1, 0, 5, 1'b1);
        tick();
        chk("setwins_q", int'(q), 0);
        chk("setwins_tc", int'(tc), 1);
        chk("setwins_ovf", int'(ovf), 1);
        drive(1'b0, 1'b0, 1'b1, 0, 5, 1'b1);
        tick();
        chk("clr_ovf1", int'(ovf), 0);

        // modulus = 0: stays at 0 with tc asserted every enabled cycle.
        drive(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        tick();
        chk("m0_up_q", int'(q), 0);
        chk("m0_up_tc", int'(tc), 1);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        tick();
        chk("m0_dn_q", int'(q), 0);
        chk("m0_dn_tc", int'(tc), 1);

        // Async reset at q=6, then resume counting from 0.
        drive(1'b1, 1'b0, 1'b1, 6, 9, 1'b0);
        tick();
        chk("pre_rst_q", int'(q), 6);
        drive(1'b0, 1'b0, 1'b1, 0, 9, 1'b0);
        tick();
        async_pulse(1'b1);
        drive(1'b0, 1'b1, 1'b1, 0, 9, 1'b0);
        tick();
        chk("resume_q", int'(q), 1);

        // Randomized phase with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, MASK)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, MASK)),
                  $urandom_range(0, 7) == 0);
            tick();
            if ($urandom_range(0, 49) == 0) async_pulse(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: count enable.
REQ-005 SHALL have port up, input, 1 bit: direction (1 = up, 0 = down).
REQ-006 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-007 SHALL have port din, input, WIDTH bits: load value.
REQ-008 SHALL have port modulus, input, WIDTH bits: terminal value (the count sequence is 0..modulus).
REQ-009 SHALL have port clr_ovf, input, 1 bit: clear for the sticky overflow flag.
REQ-010 SHALL have port q, output, WIDTH bits: current count.
REQ-011 SHALL have port tc, output, 1 bit: registered one-cycle wrap pulse.
REQ-012 SHALL have port ovf, output, 1 bit: sticky wrap flag.

Function
REQ-013 SHALL implement each bit of q as a JK toggle cell.
- J = K = t[i]; next q[i] = q[i] ^ t[i].
- t[i] derived synchronously from en, up, load and the wrap decode.
REQ-014 SHALL update the count per rising clk edge by priority: load > en > hold.
REQ-015 SHALL, when load=1, set q <= din regardless of en, up and modulus.
- din is not range-checked.
- No tc pulse on a load.
REQ-016 SHALL, when load=0 and en=0, hold q unchanged and drive tc=0.
REQ-017 SHALL, when load=0, en=1, up=1, count as follows:
- q < modulus: q <= q+1.
- q >= modulus: q <= 0 and the wrap event fires.
REQ-018 SHALL, when load=0, en=1, up=0, count as follows:
- q == 0: q <= modulus and the wrap event fires.
- Otherwise: q <= q-1, including when q > modulus.
REQ-019 SHALL, on a wrap event, drive tc=1 for exactly the cycle in which the wrapped q value is presented (tc registered alongside q); tc SHALL be 0 otherwise.
REQ-020 SHALL set ovf to 1 on a wrap event and hold it until cleared.
REQ-021 SHALL clear ovf to 0 on clr_ovf=1; simultaneous clr_ovf and wrap event leaves ovf=1 (set wins).
REQ-022 SHALL treat modulus=0 as a valid terminal value:
- up: q stays at 0 and tc=1 every enabled cycle.
- down: same.
REQ-023 SHALL sample modulus each cycle; a modulus change takes effect on the next edge without reset.
REQ-024 SHALL keep all arithmetic modulo 2^WIDTH, with no carry-out beyond WIDTH.
REQ-025 SHALL have no combinational path from any input to q, tc or ovf.

Reset
REQ-026 SHALL, while rst=1, immediately (asynchronously) force q=0, tc=0 and ovf=0, independent of clk.
REQ-027 SHALL, asserting rst mid-count, abandon any pending load or count; the first edge after rst deasserts SHALL operate normally from q=0.
REQ-028 SHALL define every output only by rst, with no dependence on power-up state.

Verification
REQ-029 SHALL be verified (WIDTH=4) by the following directed scenarios:
- Reset then count up: rst pulse, modulus=9, en=1, up=1 for 12 edges -> q 1,2,...,9,0,1,2; tc=1 only with q=0; ovf=1 after the wrap.
- Count down: modulus=5, load din=2, then en=1, up=0 for 4 edges -> q 2,1,0,5,4; tc=1 with q=5.
- Out-of-range load: modulus=5, load din=12, en=1 -> up: next q=0, tc=1; down from 12: q=11.
- Priority and hold: load=1 with en=1, din=7 -> q=7, tc=0; en=0 for 3 edges -> q stays 7.
- Flag control: clr_ovf=1 on the same edge as a wrap -> ovf stays 1; clr_ovf alone -> ovf=0.
- Async reset: rst asserted between edges while q=6 -> q=0, tc=0, ovf=0 before the next edge; counting resumes from 0.
